// File: rtl/axi_vdma_pkg.sv
// Shared state encoding and AXI constants for the read-side burst splitter.
package axi_vdma_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CALC = 3'd1,
      ADDR = 3'd2,
      DATA = 3'd3,
      DONE = 3'd4
   } state_t;

   localparam int         PAGE_BYTES  = 4096;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [3:0] ARCACHE_DEF = 4'b0011;

endpackage

// File: rtl/read_burst_split_if.sv
// AXI4 read address and read data channels between the splitter and memory.
interface read_burst_split_if #(
   parameter int ASIZE     = 29,
   parameter int LSIZE     = 9,
   parameter int AXI_DSIZE = 256,
   parameter int IDSIZE    = 3
);
   // Both channels use plain AXI valid/ready: a transfer happens on the
   // clock edge where valid and ready are both high; the source holds its
   // payload stable while valid is high and ready is low.
   logic [IDSIZE-1:0]    axi_arid;
   logic [ASIZE-1:0]     axi_araddr;
   logic [LSIZE-1:0]     axi_arlen;
   logic [2:0]           axi_arsize;
   logic [1:0]           axi_arburst;
   logic                 axi_arlock;
   logic [3:0]           axi_arcache;
   logic [2:0]           axi_arprot;
   logic [3:0]           axi_arqos;
   logic                 axi_arvalid;
   logic                 axi_arready;
   logic [IDSIZE-1:0]    axi_rid;
   logic [AXI_DSIZE-1:0] axi_rdata;
   logic [1:0]           axi_rresp;
   logic                 axi_rlast;
   logic                 axi_rvalid;
   logic                 axi_rready;

   modport master (
      output axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
             axi_arlock, axi_arcache, axi_arprot, axi_arqos, axi_arvalid,
      input  axi_arready,
      input  axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
      output axi_rready
   );

   modport slave (
      input  axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
             axi_arlock, axi_arcache, axi_arprot, axi_arqos, axi_arvalid,
      output axi_arready,
      output axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
      input  axi_rready
   );

endinterface

// File: rtl/burst_len_calc.sv
// Beats for the next AR burst: min of beats left, MAX_BURST and room to the 4 KB page end.
module burst_len_calc
   import axi_vdma_pkg::*;
#(
   parameter int BYTES     = 32,
   parameter int MAX_BURST = 256
) (
   input  logic [15:0] remaining,
   input  logic [11:0] page_off,
   output logic [15:0] len
);

   localparam int BSHIFT = $clog2(BYTES);

   logic [12:0] page_room;
   logic [12:0] page_beats;

   assign page_room  = 13'(PAGE_BYTES) - {1'b0, page_off};
   assign page_beats = page_room >> BSHIFT;

   always_comb begin
      len = remaining;
      if (16'(MAX_BURST) < len) len = 16'(MAX_BURST);
      if (16'(page_beats) < len) len = 16'(page_beats);
   end

endmodule

// File: rtl/read_burst_split.sv
// Splits a (start address, beat count) read request into 4 KB-safe AXI4 INCR
// bursts, one outstanding at a time, and forwards the returned beats to a FIFO.
module read_burst_split
   import axi_vdma_pkg::*;
#(
   parameter int ASIZE     = 29,
   parameter int LSIZE     = 9,
   parameter int AXI_DSIZE = 256,
   parameter int IDSIZE    = 3,
   parameter int ID        = 0,
   parameter int MAX_BURST = 256
) (
   input  logic                 axi_aclk,
   input  logic                 axi_resetn,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [ASIZE-1:0]     req_addr,
   input  logic [15:0]          req_beats,
   output logic                 done,
   output logic                 err,
   read_burst_split_if.master   axi,
   input  logic                 push_ready,
   output logic                 push_en,
   output logic [AXI_DSIZE-1:0] push_data,
   output logic                 push_last,
   output state_t               dbg_state
);

   localparam int BYTES  = AXI_DSIZE / 8;
   localparam int BSHIFT = $clog2(BYTES);

   state_t            state, state_nx;
   logic [ASIZE-1:0]  addr_q;
   logic [15:0]       remaining_q;
   logic [15:0]       len_q;
   logic [15:0]       calc_len;
   logic [ASIZE-1:0]  araddr_q;
   logic [LSIZE-1:0]  arlen_q;
   logic              err_q;
   logic              req_fire;
   logic              ar_fire;
   logic              r_fire;
   logic              bad_beat;

   burst_len_calc #(.BYTES(BYTES), .MAX_BURST(MAX_BURST)) u_len_calc (
      .remaining (remaining_q),
      .page_off  (addr_q[11:0]),
      .len       (calc_len)
   );

   assign req_fire = (state == IDLE) && req_valid;
   assign ar_fire  = (state == ADDR) && axi.axi_arready;
   assign r_fire   = (state == DATA) && axi.axi_rvalid && push_ready;
   assign bad_beat = (axi.axi_rresp != RESP_OKAY) || (axi.axi_rid != IDSIZE'(ID));

   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) state <= IDLE;
      else             state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (req_valid) state_nx = (req_beats == 16'd0) ? DONE : CALC;
         CALC: state_nx = ADDR;
         ADDR: if (axi.axi_arready) state_nx = DATA;
         DATA: if (r_fire && axi.axi_rlast) state_nx = (remaining_q != 16'd0) ? CALC : DONE;
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // remaining_q counts beats not yet requested on AR, so it is already zero
   // while the final burst's data streams in.
   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         addr_q      <= '0;
         remaining_q <= '0;
         len_q       <= '0;
         araddr_q    <= '0;
         arlen_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         if (req_fire) begin
            addr_q      <= req_addr & ~ASIZE'(BYTES - 1);
            remaining_q <= req_beats;
            err_q       <= 1'b0;
         end
         if (state == CALC) begin
            len_q    <= calc_len;
            araddr_q <= addr_q;
            arlen_q  <= LSIZE'(calc_len - 16'd1);
         end
         if (ar_fire) begin
            addr_q      <= addr_q + (ASIZE'(len_q) << BSHIFT);
            remaining_q <= remaining_q - len_q;
         end
         if (r_fire && bad_beat) err_q <= 1'b1;
      end
   end

   assign req_ready       = (state == IDLE);
   assign done            = (state == DONE);
   assign err             = err_q;
   assign dbg_state       = state;

   assign axi.axi_arid    = IDSIZE'(ID);
   assign axi.axi_araddr  = araddr_q;
   assign axi.axi_arlen   = arlen_q;
   assign axi.axi_arsize  = 3'(BSHIFT);
   assign axi.axi_arburst = BURST_INCR;
   assign axi.axi_arlock  = 1'b0;
   assign axi.axi_arcache = ARCACHE_DEF;
   assign axi.axi_arprot  = 3'b000;
   assign axi.axi_arqos   = 4'b0000;
   assign axi.axi_arvalid = (state == ADDR);
   assign axi.axi_rready  = (state == DATA) && push_ready;

   assign push_en   = r_fire;
   assign push_data = axi.axi_rdata;
   assign push_last = r_fire && axi.axi_rlast && (remaining_q == 16'd0);

endmodule

// File: tb/tb_read_burst_split.sv
// Directed bench for read_burst_split: memory responder model plus scoreboards
// for AR bursts, pushed beats and done/err.
module tb_read_burst_split;
   import axi_vdma_pkg::*;

   logic         clk;
   logic         rst_n;
   logic         req_valid;
   logic         req_ready;
   logic [28:0]  req_addr;
   logic [15:0]  req_beats;
   logic         done;
   logic         err;
   logic         push_ready;
   logic         push_en;
   logic [255:0] push_data;
   logic         push_last;
   state_t       dbg_state;

   read_burst_split_if #(.ASIZE(29), .LSIZE(9), .AXI_DSIZE(256), .IDSIZE(3)) bus ();

   read_burst_split #(
      .ASIZE(29), .LSIZE(9), .AXI_DSIZE(256), .IDSIZE(3), .ID(0), .MAX_BURST(256)
   ) dut (
      .axi_aclk   (clk),
      .axi_resetn (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_beats  (req_beats),
      .done       (done),
      .err        (err),
      .axi        (bus),
      .push_ready (push_ready),
      .push_en    (push_en),
      .push_data  (push_data),
      .push_last  (push_last),
      .dbg_state  (dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   logic [256:0] exp_q[$];
   logic [37:0]  ar_exp_q[$];
   logic         exp_err_q[$];
   int total = 0;
   int bad = 0;
   int push_cnt = 0;
   int done_cnt = 0;

   bit ar_rand = 0;
   bit pr_rand = 0;
   int err_beat = -1;
   int bad_id_beat = -1;
   int slave_beat = 0;

   function automatic logic [255:0] beat_word(input logic [28:0] a);
      logic [255:0] w;
      for (int k = 0; k < 8; k++) w[32*k +: 32] = {3'b000, a} + 32'(k) * 32'h0101_0101;
      return w;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic exp_ar(input logic [28:0] a, input int beats);
      ar_exp_q.push_back({a, 9'(beats - 1)});
   endtask

   // ---------------- memory responder ----------------
   logic [28:0] sl_addr_q[$];
   int          sl_beats_q[$];

   initial begin : slave
      bit ar_fire;
      bit r_fire;
      int cur_beat;
      cur_beat = 0;
      bus.axi_arready = 1'b0;
      bus.axi_rvalid  = 1'b0;
      bus.axi_rdata   = '0;
      bus.axi_rresp   = 2'b00;
      bus.axi_rid     = 3'd0;
      bus.axi_rlast   = 1'b0;
      forever begin
         @(negedge clk);
         ar_fire = bus.axi_arvalid && bus.axi_arready;
         r_fire  = bus.axi_rvalid && bus.axi_rready;
         @(posedge clk);
         #1;
         if (!rst_n) begin
            sl_addr_q.delete();
            sl_beats_q.delete();
            cur_beat = 0;
         end else begin
            if (r_fire && sl_beats_q.size() > 0) begin
               cur_beat++;
               slave_beat++;
               if (cur_beat == sl_beats_q[0]) begin
                  void'(sl_addr_q.pop_front());
                  void'(sl_beats_q.pop_front());
                  cur_beat = 0;
               end
            end
            if (ar_fire) begin
               sl_addr_q.push_back(bus.axi_araddr);
               sl_beats_q.push_back(int'(bus.axi_arlen) + 1);
            end
         end
         bus.axi_arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         if (sl_beats_q.size() > 0) begin
            bus.axi_rvalid = 1'b1;
            bus.axi_rdata  = beat_word(sl_addr_q[0] + 29'(cur_beat * 32));
            bus.axi_rlast  = (cur_beat == sl_beats_q[0] - 1);
            bus.axi_rresp  = (slave_beat == err_beat) ? 2'b10 : 2'b00;
            bus.axi_rid    = (slave_beat == bad_id_beat) ? 3'd5 : 3'd0;
         end else begin
            bus.axi_rvalid = 1'b0;
            bus.axi_rlast  = 1'b0;
            bus.axi_rresp  = 2'b00;
            bus.axi_rid    = 3'd0;
         end
      end
   end

   initial begin : push_ready_drv
      push_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         push_ready = pr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // ---------------- monitors ----------------
   initial begin : mon_push
      logic [256:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && push_en) begin
            push_cnt++;
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL push_unexpected: got %h expected none", push_data);
            end else begin
               e = exp_q.pop_front();
               if ({push_last, push_data} !== e) begin
                  bad++;
                  $display("FAIL push_beat: got last=%0b data=%h expected last=%0b data=%h",
                           push_last, push_data, e[256], e[255:0]);
               end
            end
         end
      end
   end

   initial begin : mon_ar
      logic [37:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && bus.axi_arvalid && bus.axi_arready) begin
            total++;
            if (ar_exp_q.size() == 0) begin
               bad++;
               $display("FAIL ar_unexpected: got addr=%h len=%0d expected none",
                        bus.axi_araddr, bus.axi_arlen);
            end else begin
               e = ar_exp_q.pop_front();
               if ({bus.axi_araddr, bus.axi_arlen} !== e) begin
                  bad++;
                  $display("FAIL ar_burst: got addr=%h len=%0d expected addr=%h len=%0d",
                           bus.axi_araddr, bus.axi_arlen, e[37:9], e[8:0]);
               end
            end
            chk("ar_const",
                64'({bus.axi_arid, bus.axi_arsize, bus.axi_arburst, bus.axi_arlock,
                     bus.axi_arcache, bus.axi_arprot, bus.axi_arqos}),
                64'({3'd0, 3'd5, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0}));
         end
      end
   end

   initial begin : mon_done
      logic e;
      forever begin
         @(negedge clk);
         if (rst_n && done) begin
            done_cnt++;
            total++;
            if (exp_err_q.size() == 0) begin
               bad++;
               $display("FAIL done_unexpected: got done=1 expected none");
            end else begin
               e = exp_err_q.pop_front();
               if (err !== e) begin
                  bad++;
                  $display("FAIL done_err: got %0b expected %0b", err, e);
               end
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic run_req(input logic [28:0] a, input int beats, input logic exp_e);
      logic [28:0] base;
      int d0;
      int p0;
      int n;
      base = a & ~29'h1F;
      for (int i = 0; i < beats; i++)
         exp_q.push_back({1'(i == beats - 1), beat_word(base + 29'(i * 32))});
      exp_err_q.push_back(exp_e);
      slave_beat = 0;
      d0 = done_cnt;
      p0 = push_cnt;
      @(posedge clk);
      #1;
      req_addr  = a;
      req_beats = 16'(beats);
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("req_ready_busy", 64'(req_ready), 64'd0);
      chk("err_clear_on_accept", 64'(err), 64'd0);
      if (beats == 0) begin
         chk("noop_done_lat", 64'(done), 64'd1);
      end else begin
         chk("arvalid_lat1", 64'(bus.axi_arvalid), 64'd0);
         @(posedge clk);
         #1;
         chk("arvalid_lat2", 64'(bus.axi_arvalid), 64'd1);
      end
      n = 0;
      while (done_cnt == d0 && n < 5000) begin
         @(posedge clk);
         n++;
      end
      chk("done_timeout", 64'(done_cnt != d0), 64'd1);
      @(posedge clk);
      #1;
      chk("err_sticky", 64'(err), 64'(exp_e));
      chk("req_ready_idle", 64'(req_ready), 64'd1);
      chk("push_remaining", 64'(exp_q.size()), 64'd0);
      chk("ar_remaining", 64'(ar_exp_q.size()), 64'd0);
      chk("push_count", 64'(push_cnt - p0), 64'(beats));
      repeat (3) @(posedge clk);
      #1;
      chk("done_once", 64'(done_cnt - d0), 64'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_arvalid"},   64'(bus.axi_arvalid), 64'd0);
      chk({tag, "_rready"},    64'(bus.axi_rready), 64'd0);
      chk({tag, "_push_en"},   64'(push_en), 64'd0);
      chk({tag, "_push_last"}, 64'(push_last), 64'd0);
      chk({tag, "_done"},      64'(done), 64'd0);
      chk({tag, "_err"},       64'(err), 64'd0);
      chk({tag, "_state"},     64'(dbg_state), 64'(IDLE));
   endtask

   task automatic reset_mid_burst();
      int d0;
      int p0;
      int n;
      for (int i = 0; i < 64; i++)
         exp_q.push_back({1'(i == 63), beat_word(29'h0C000 + 29'(i * 32))});
      exp_err_q.push_back(1'b0);
      exp_ar(29'h0C000, 64);
      slave_beat = 0;
      pr_rand = 1;
      d0 = done_cnt;
      p0 = push_cnt;
      @(posedge clk);
      #1;
      req_addr  = 29'h0C000;
      req_beats = 16'd64;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      n = 0;
      while (push_cnt - p0 < 10 && n < 3000) begin
         @(posedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      chk("rst_in_data", 64'(dbg_state), 64'(DATA));
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_async");
      exp_q.delete();
      exp_err_q.delete();
      ar_exp_q.delete();
      pr_rand = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("rst_rel_req_ready", 64'(req_ready), 64'd1);
      repeat (20) @(posedge clk);
      #1;
      chk("rst_no_done", 64'(done_cnt - d0), 64'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin : main
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_addr  = '0;
      req_beats = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check_reset_outputs("reset");
      chk("reset_req_ready", 64'(req_ready), 64'd1);
      chk("reset_araddr", 64'(bus.axi_araddr), 64'd0);
      chk("reset_arlen", 64'(bus.axi_arlen), 64'd0);

      // 300 beats from 0: page limit gives 128 + 128 + 44
      exp_ar(29'h00000, 128);
      exp_ar(29'h01000, 128);
      exp_ar(29'h02000, 44);
      run_req(29'h00000, 300, 1'b0);

      // 0xF00: 8 beats to the page edge, then 12
      ar_rand = 1;
      exp_ar(29'h00F00, 8);
      exp_ar(29'h01000, 12);
      run_req(29'h00F00, 20, 1'b0);
      ar_rand = 0;

      run_req(29'h03000, 0, 1'b0);

      pr_rand = 1;
      exp_ar(29'h04000, 128);
      run_req(29'h04000, 128, 1'b0);
      pr_rand = 0;

      err_beat = 5;
      exp_ar(29'h08000, 10);
      run_req(29'h08000, 10, 1'b1);
      err_beat = -1;

      exp_ar(29'h09000, 16);
      run_req(29'h09000, 16, 1'b0);

      bad_id_beat = 2;
      exp_ar(29'h0A000, 4);
      run_req(29'h0A000, 4, 1'b1);
      bad_id_beat = -1;

      // unaligned start rounds down to the beat boundary
      exp_ar(29'h0B000, 3);
      run_req(29'h0B013, 3, 1'b0);

      reset_mid_burst();

      exp_ar(29'h0D000, 40);
      run_req(29'h0D000, 40, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #400000;
      bad++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
